// File: rtl/q_8_41_pair_sched.sv
// ---------------------------------------------------------------------------
// q_8_41_pair_sched
//
// Two-channel pair scheduler for the q_8_41 decimate-by-2 datapath.
// Streams A and B compete for a single decimator. The granted channel is
// locked for one sample pair. The pair is captured into P0/P1 and then
// summed at full width into the R0 output register, tagged with its
// source channel.
//
// Parameters:
//   W          sample width in bits
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   en         permits starting new pairs (a pair in progress always completes)
//   clr        synchronous flush of a partial or completed-but-unloaded pair
//   a_valid    channel A sample available
//   a_data     channel A sample (unsigned, W bits)
//   a_ready    channel A sample accepted when a_valid && a_ready
//   b_valid    channel B sample available
//   b_data     channel B sample (unsigned, W bits)
//   b_ready    channel B sample accepted when b_valid && b_ready
//   out_valid  R0 holds an unconsumed result
//   out_data   R0 = P0 + P1 (W+1 bits, no truncation)
//   out_ch     source channel of out_data (0 = A, 1 = B)
//   out_ready  consumer accepts R0 when out_valid && out_ready
// ---------------------------------------------------------------------------
module q_8_41_pair_sched #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic         a_valid,
    input  logic [W-1:0] a_data,
    output logic         a_ready,
    input  logic         b_valid,
    input  logic [W-1:0] b_data,
    output logic         b_ready,
    output logic         out_valid,
    output logic [W:0]   out_data,
    output logic         out_ch,
    input  logic         out_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,  // waiting for the first sample of a pair
        S_ONE  = 2'd1,  // first sample held in P0, grant locked
        S_FULL = 2'd2,  // both samples held, first attempt to load R0
        S_WAIT = 2'd3   // both samples held, R0 was busy
    } state_t;

    state_t         state_r;
    logic [W-1:0]   p0_r;
    logic [W-1:0]   p1_r;
    logic [W:0]     r0_r;
    logic           out_valid_r;
    logic           out_ch_r;
    logic           gnt_r;
    logic           last_r;

    logic           offer_a_s;
    logic           offer_b_s;
    logic           a_ready_s;
    logic           b_ready_s;
    logic           hs_a_s;
    logic           hs_b_s;
    logic           hs_any_s;
    logic [W-1:0]   hs_data_s;
    logic           r0_free_s;
    logic           consume_s;
    logic           load_s;
    logic [W:0]     sum_s;

    // Idle-state offer: a lone valid wins; with both valid, the channel that
    // was not granted last time wins (round-robin).
    always_comb begin
        offer_a_s = 1'b0;
        offer_b_s = 1'b0;
        if (a_valid && b_valid) begin
            offer_a_s = last_r;
            offer_b_s = ~last_r;
        end else begin
            offer_a_s = a_valid;
            offer_b_s = b_valid;
        end
    end

    // Ready generation. Readies are forced low during reset and flush; in
    // S_ONE only the locked channel may deliver its second sample.
    always_comb begin
        a_ready_s = 1'b0;
        b_ready_s = 1'b0;
        if (!rst || clr) begin
            a_ready_s = 1'b0;
            b_ready_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (en) begin
                        a_ready_s = offer_a_s;
                        b_ready_s = offer_b_s;
                    end else begin
                        a_ready_s = 1'b0;
                        b_ready_s = 1'b0;
                    end
                end
                S_ONE: begin
                    a_ready_s = ~gnt_r;
                    b_ready_s = gnt_r;
                end
                default: begin
                    a_ready_s = 1'b0;
                    b_ready_s = 1'b0;
                end
            endcase
        end
    end

    // Handshake decode and the R0 load/consume conditions.
    always_comb begin
        hs_a_s    = a_valid && a_ready_s;
        hs_b_s    = b_valid && b_ready_s;
        hs_any_s  = hs_a_s || hs_b_s;
        if (hs_b_s) begin
            hs_data_s = b_data;
        end else begin
            hs_data_s = a_data;
        end
        r0_free_s = ~out_valid_r || out_ready;
        consume_s = out_valid_r && out_ready;
        // A flush discards a completed pair, so R0 is never loaded under clr.
        load_s    = ((state_r == S_FULL) || (state_r == S_WAIT)) && r0_free_s && !clr;
        sum_s     = {1'b0, p0_r} + {1'b0, p1_r};
    end

    // Pair sequencing FSM with the P0/P1 capture registers and grant tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            p0_r    <= {W{1'b0}};
            p1_r    <= {W{1'b0}};
            gnt_r   <= 1'b0;
            last_r  <= 1'b1;
        end else if (clr) begin
            state_r <= S_IDLE;
            p0_r    <= {W{1'b0}};
            p1_r    <= {W{1'b0}};
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (hs_any_s) begin
                        p0_r    <= hs_data_s;
                        gnt_r   <= hs_b_s;
                        last_r  <= hs_b_s;
                        state_r <= S_ONE;
                    end else begin
                        p0_r    <= {W{1'b0}};
                        p1_r    <= {W{1'b0}};
                        state_r <= S_IDLE;
                    end
                end
                S_ONE: begin
                    if (hs_any_s) begin
                        p1_r    <= hs_data_s;
                        state_r <= S_FULL;
                    end else begin
                        state_r <= S_ONE;
                    end
                end
                S_FULL, S_WAIT: begin
                    if (r0_free_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        state_r <= S_WAIT;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Output register: a load wins over a consume in the same cycle, so a
    // back-to-back consume+load keeps out_valid high with fresh data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r0_r        <= {(W+1){1'b0}};
            out_valid_r <= 1'b0;
            out_ch_r    <= 1'b0;
        end else if (load_s) begin
            r0_r        <= sum_s;
            out_ch_r    <= gnt_r;
            out_valid_r <= 1'b1;
        end else if (consume_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign a_ready   = a_ready_s;
    assign b_ready   = b_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = r0_r;
    assign out_ch    = out_ch_r;

endmodule

// File: doc/q_8_41_pair_sched.md
# q_8_41_pair_sched

Two-channel scheduler for the q_8_41 decimate-by-2 datapath. It arbitrates between sample streams A and B and locks the granted channel for one sample pair. It sequences the pair through the P0/P1 pipeline registers, then into the R0 output register as a full-width sum, tagged with its source channel. It sits between the two sample producers and a single downstream consumer, so one decimator datapath serves both channels.

## Interface
Parameters:
- W, 8, sample width in bits

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  permits starting new pairs; does not abort a pair in progress
- clr  in  1  synchronous flush of a partial pair; higher priority than en and the handshakes
- a_valid  in  1  channel A sample available
- a_data  in  W  channel A sample, unsigned
- a_ready  out  1  channel A sample accepted this cycle when a_valid && a_ready
- b_valid  in  1  channel B sample available
- b_data  in  W  channel B sample, unsigned
- b_ready  out  1  channel B handshake, same rules as A
- out_valid  out  1  R0 holds an unconsumed result
- out_data  out  W+1  R0 = P0 + P1
- out_ch  out  1  source channel of out_data: 0 = A, 1 = B
- out_ready  in  1  consumer accepts R0 when out_valid && out_ready

## Operation
- Registers:
  - state, one of S_idle, S_1, S_full, S_wait
  - P0, P1 (W bits each)
  - R0 (W+1 bits), out_valid, out_ch
  - gnt (current channel), last (last granted channel)
- Reset (rst low), applied asynchronously:
  - state = S_idle, P0 = P1 = 0, R0 = 0, out_valid = 0, out_ch = 0, gnt = 0, last = 1 (A has first priority).
  - a_ready = b_ready = 0 while rst is low.
- S_idle:
  - Readies are 0 unless en = 1 and clr = 0.
  - If only one valid is high, that channel is offered.
  - If both are high, offer the channel != last (round-robin).
  - The offered channel's ready = 1 and the other ready = 0. Ready may depend combinationally on valid.
  - On handshake: P0 <= data, gnt <= channel, last <= channel, go to S_1.
  - With no valid, stay in S_idle and clear P0 and P1.
- S_1:
  - Only the gnt channel's ready = 1. en is ignored here.
  - On handshake: P1 <= data, go to S_full.
  - Otherwise hold in S_1 indefinitely.
- S_full:
  - If R0 is free (out_valid = 0, or out_ready = 1 this cycle): R0 <= P0 + P1 (zero-extended, no truncation), out_ch <= gnt, out_valid <= 1, go to S_idle.
  - If R0 is not free: go to S_wait.
  - Both readies are 0.
- S_wait:
  - Same as S_full, except that when R0 is not free the state stays in S_wait.
  - Both readies are 0. P0 and P1 hold.
- Output register:
  - out_valid clears on a consumer handshake unless it is reloaded in the same cycle.
  - A simultaneous consume and load leaves out_valid = 1 with the new data.
- clr = 1, in any state, takes effect at the next edge:
  - state = S_idle, P0 = P1 = 0.
  - Readies are 0 in that cycle.
  - R0, out_valid, out_ch and last are unaffected.
  - In S_full or S_wait, clr discards the pair and R0 is not loaded.
- Default or illegal state encoding: go to S_idle.

## Timing
- First sample handshake at edge k, second at edge k+1 at the earliest. S_full is active in cycle k+2, and out_valid is visible from cycle k+3.
- Latency from the second sample handshake to out_valid is 2 cycles when R0 is free.
- Maximum throughput is one pair every 3 cycles: S_idle, S_1, S_full.
- Backpressure: while out_valid = 1 and out_ready = 0, at most one completed pair waits in P0/P1 (S_wait), and no new samples are accepted.
- Grant lock: a channel keeps the grant from its first sample until its second sample. The other channel is never accepted between them, even if the first channel's valid drops.

## Test plan
- Reset, then en = 1, A sends 0x10 and 0x20 back-to-back, out_ready = 1 -> out_data = 0x030, out_ch = 0, out_valid high for exactly 1 cycle, 2 cycles after the second handshake.
- Overflow: B sends 0xFF and 0xFF -> out_data = 0x1FE, out_ch = 1.
- Both valids held high continuously with out_ready = 1 -> grants alternate A, B, A, B. The first grant goes to A. One result every 3 cycles.
- out_ready = 0 after the first result, with a second pair (0x01, 0x02) completed -> state is S_wait, readies stay 0, out_data holds the first result. Raising out_ready for one cycle -> out_data = 0x003 on the next cycle.
- A sends 0x05, then clr = 1 in S_1, then B sends 0x07 and 0x08 -> out_data = 0x00F, out_ch = 1. The partial A pair is never output.
- rst asserted low in S_1 mid-pair -> out_valid, readies, P0 and P1 go to 0 immediately, without waiting for a clock edge. After release, the first grant goes to A. en = 0 in S_idle -> no readies asserted despite valids.
